// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   parity_t      : parity mode selector for the receiver parameter.
//   rx_state_t    : receive FSM state encoding.
//   rx_flags_t    : status flags stored above the data bits in each FIFO entry.
//                   A FIFO entry is {rx_flags_t, data[DATA_BITS-1:0]}.
//   clks_per_bit  : integer clocks per bit, truncated.
//   entry_width   : stored entry width for a given data width.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    // Entry layout, MSB first: brk, frame_err, parity_err, then data.
    typedef struct packed {
        logic brk;
        logic frame_err;
        logic parity_err;
    } rx_flags_t;

    localparam int FLAG_BITS = $bits(rx_flags_t);

    function automatic int clks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

    function automatic int entry_width(input int data_bits);
        return data_bits + FLAG_BITS;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO with valid/ready
// on both sides.
//   clk, reset           : clock, synchronous active-high reset (pointers/count).
//   in_data/in_valid     : write side; in_ready is high when not full, or when
//   in_ready               full but the head is being popped in the same cycle.
//   out_data/out_valid   : head entry and non-empty flag (registered, no bypass).
//   out_ready            : pop when out_valid && out_ready.
//   count                : number of stored entries, 0..DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    always_comb begin
        out_valid = (count_q != '0);
        // Accepting while full is safe only because the head leaves this cycle.
        in_ready  = (count_q != FULL_CNT) || out_ready;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        out_data  = mem[rd_ptr_q];
        count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver feeding a valid/ready FIFO.
//   clk, reset     : system clock, synchronous active-high reset.
//   rx_pin         : asynchronous serial input, idles high.
//   rx_data        : head-of-FIFO data (0 when empty).
//   rx_parity_err  : head entry failed its parity check.
//   rx_frame_err   : head entry had a low stop bit.
//   rx_break       : head entry is a break condition.
//   rx_valid       : FIFO not empty.
//   rx_ready       : consumer pops the head when rx_valid && rx_ready.
//   fifo_count     : number of stored entries.
//   overrun        : one-cycle pulse when a finished frame is dropped (FIFO full).
//   busy           : receive FSM is not in IDLE.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int      CLOCK_HZ   = 20_000_000,
    parameter int      BAUD       = 115200,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PARITY_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_pin,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_break,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          busy
);

    localparam int CPB     = clks_per_bit(CLOCK_HZ, BAUD);
    localparam int HALF    = CPB / 2;
    localparam int CNT_W   = $clog2(CPB);
    localparam int ENTRY_W = entry_width(DATA_BITS);
    localparam bit PAR_EN  = (PARITY != PARITY_NONE);
    localparam bit PAR_ODD = (PARITY == PARITY_ODD);

    // Synchroniser stage
    logic              rx_meta_q, rx_s_q;
    logic [1:0]        settle_q, settle_d;
    logic              sync_ready;

    // Receive FSM stage
    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic              par_err_q, par_err_d;
    logic              frame_err_q, frame_err_d;
    logic              any_one_q, any_one_d;
    logic              tick, frame_err_nxt, any_one_nxt;
    rx_flags_t         flags_v;

    // Push stage
    logic              push_q, push_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    // FIFO / head stage
    logic              fifo_in_ready;
    logic [ENTRY_W-1:0] fifo_out_data;
    logic              fifo_out_valid;
    rx_flags_t         head_flags;
    logic [DATA_BITS-1:0] head_data;

    // The synchroniser flops come out of reset at 1, which would look like an
    // idle line for two cycles. settle_q holds WAIT_IDLE until both stages
    // carry real pin samples, so a line held low through reset is not decoded.
    assign sync_ready = (settle_q == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            settle_q    <= 2'd0;
            state_q     <= ST_WAIT_IDLE;
            cyc_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            any_one_q   <= 1'b0;
            push_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_pin;
            rx_s_q      <= rx_meta_q;
            settle_q    <= settle_d;
            state_q     <= state_d;
            cyc_cnt_q   <= cyc_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            any_one_q   <= any_one_d;
            push_q      <= push_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // Datapath registers carry no reset; push_q qualifies entry_q.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        entry_q <= entry_d;
    end

    always_comb begin
        settle_d      = sync_ready ? settle_q : settle_q + 2'd1;
        state_d       = state_q;
        cyc_cnt_d     = cyc_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_err_d     = par_err_q;
        frame_err_d   = frame_err_q;
        any_one_d     = any_one_q;
        push_d        = 1'b0;
        entry_d       = entry_q;
        flags_v       = '0;
        frame_err_nxt = frame_err_q | ~rx_s_q;
        any_one_nxt   = any_one_q | rx_s_q;
        // START waits half a bit to land mid-bit; later states step a full bit.
        tick = (state_q == ST_START) ? (cyc_cnt_q == CNT_W'(HALF - 1))
                                     : (cyc_cnt_q == CNT_W'(CPB - 1));

        if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
            cyc_cnt_d = tick ? '0 : cyc_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_WAIT_IDLE: begin
                if (sync_ready && rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = ST_START;
                    cyc_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DATA;
                        bit_cnt_d   = '0;
                        par_err_d   = 1'b0;
                        frame_err_d = 1'b0;
                        any_one_d   = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    any_one_d = any_one_nxt;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_err_d = ((^shift_q) ^ rx_s_q) != PAR_ODD;
                    any_one_d = any_one_nxt;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        push_d    = 1'b1;
                        bit_cnt_d = '0;
                        if (any_one_nxt) begin
                            flags_v.frame_err  = frame_err_nxt;
                            flags_v.parity_err = par_err_q;
                            entry_d = {flags_v, shift_q};
                            state_d = ST_IDLE;
                        end else begin
                            flags_v.brk       = 1'b1;
                            flags_v.frame_err = 1'b1;
                            entry_d = {flags_v, {DATA_BITS{1'b0}}};
                            state_d = ST_BREAK_WAIT;
                        end
                    end else begin
                        bit_cnt_d   = bit_cnt_q + 4'd1;
                        frame_err_d = frame_err_nxt;
                        any_one_d   = any_one_nxt;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        overrun_d     = push_q && !fifo_in_ready;
        head_flags    = rx_flags_t'(fifo_out_data[ENTRY_W-1 -: FLAG_BITS]);
        head_data     = fifo_out_data[DATA_BITS-1:0];
        rx_valid      = fifo_out_valid;
        rx_data       = fifo_out_valid ? head_data : '0;
        rx_parity_err = fifo_out_valid && head_flags.parity_err;
        rx_frame_err  = fifo_out_valid && head_flags.frame_err;
        rx_break      = fifo_out_valid && head_flags.brk;
        busy          = busy_q;
        overrun       = overrun_q;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_data   (entry_q),
        .in_valid  (push_q),
        .in_ready  (fifo_in_ready),
        .out_data  (fifo_out_data),
        .out_valid (fifo_out_valid),
        .out_ready (rx_ready),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo. Four instances cover the
// default 8N1 build, 7E1, 8N2 and a 4-deep FIFO; all share clk and reset.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CPB = 173;   // 20 MHz / 115200, truncated

    logic clk = 1'b0;
    logic reset;
    always #25 clk = ~clk;      // 20 MHz

    logic rx_a, rx_p, rx_s, rx_f;
    logic rdy_a, rdy_p, rdy_s, rdy_f;
    logic [7:0] dat_a, dat_s, dat_f;
    logic [6:0] dat_p;
    logic pe_a, pe_p, pe_s, pe_f, fe_a, fe_p, fe_s, fe_f, bk_a, bk_p, bk_s, bk_f;
    logic vld_a, vld_p, vld_s, vld_f, ovr_a, ovr_p, ovr_s, ovr_f;
    logic bsy_a, bsy_p, bsy_s, bsy_f;
    logic [4:0] cnt_a, cnt_p, cnt_s;
    logic [2:0] cnt_f;

    uart_rx_fifo u_a (.clk(clk), .reset(reset), .rx_pin(rx_a), .rx_data(dat_a),
        .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_break(bk_a), .rx_valid(vld_a),
        .rx_ready(rdy_a), .fifo_count(cnt_a), .overrun(ovr_a), .busy(bsy_a));

    uart_rx_fifo #(.DATA_BITS(7), .PARITY(PARITY_EVEN)) u_p (.clk(clk), .reset(reset),
        .rx_pin(rx_p), .rx_data(dat_p), .rx_parity_err(pe_p), .rx_frame_err(fe_p),
        .rx_break(bk_p), .rx_valid(vld_p), .rx_ready(rdy_p), .fifo_count(cnt_p),
        .overrun(ovr_p), .busy(bsy_p));

    uart_rx_fifo #(.STOP_BITS(2)) u_s (.clk(clk), .reset(reset), .rx_pin(rx_s),
        .rx_data(dat_s), .rx_parity_err(pe_s), .rx_frame_err(fe_s), .rx_break(bk_s),
        .rx_valid(vld_s), .rx_ready(rdy_s), .fifo_count(cnt_s), .overrun(ovr_s),
        .busy(bsy_s));

    uart_rx_fifo #(.FIFO_DEPTH(4)) u_f (.clk(clk), .reset(reset), .rx_pin(rx_f),
        .rx_data(dat_f), .rx_parity_err(pe_f), .rx_frame_err(fe_f), .rx_break(bk_f),
        .rx_valid(vld_f), .rx_ready(rdy_f), .fifo_count(cnt_f), .overrun(ovr_f),
        .busy(bsy_f));

    int checks = 0;
    int errors = 0;
    int pops_a = 0;
    int ovr_cnt_a = 0, ovr_cnt_p = 0, ovr_cnt_s = 0, ovr_cnt_f = 0;

    always @(posedge clk) begin
        if (vld_a && rdy_a) pops_a <= pops_a + 1;
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        if (ovr_p) ovr_cnt_p <= ovr_cnt_p + 1;
        if (ovr_s) ovr_cnt_s <= ovr_cnt_s + 1;
        if (ovr_f) ovr_cnt_f <= ovr_cnt_f + 1;
    end

    typedef struct {
        int         cfg;        // 0:8N1 1:7E1 2:8N2 3:8N1 depth 4
        logic [8:0] data;
        int         nbits;
        bit         par_en;
        bit         par_bit;
        int         nstop;
        bit         stop2_low;  // drive the second stop bit low
        logic [8:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
        bit         exp_brk;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int cfg, input logic v);
        case (cfg)
            0: rx_a = v;
            1: rx_p = v;
            2: rx_s = v;
            default: rx_f = v;
        endcase
    endtask

    function automatic logic get_valid(input int cfg);
        case (cfg)
            0: return vld_a;
            1: return vld_p;
            2: return vld_s;
            default: return vld_f;
        endcase
    endfunction

    function automatic logic [8:0] get_data(input int cfg);
        case (cfg)
            0: return {1'b0, dat_a};
            1: return {2'b0, dat_p};
            2: return {1'b0, dat_s};
            default: return {1'b0, dat_f};
        endcase
    endfunction

    // {break, frame_err, parity_err}
    function automatic logic [2:0] get_flags(input int cfg);
        case (cfg)
            0: return {bk_a, fe_a, pe_a};
            1: return {bk_p, fe_p, pe_p};
            2: return {bk_s, fe_s, pe_s};
            default: return {bk_f, fe_f, pe_f};
        endcase
    endfunction

    function automatic logic get_busy(input int cfg);
        case (cfg)
            0: return bsy_a;
            1: return bsy_p;
            2: return bsy_s;
            default: return bsy_f;
        endcase
    endfunction

    function automatic int get_count(input int cfg);
        case (cfg)
            0: return int'(cnt_a);
            1: return int'(cnt_p);
            2: return int'(cnt_s);
            default: return int'(cnt_f);
        endcase
    endfunction

    // Starts on a negedge; each bit is CPB clocks long, changes on negedges.
    task automatic send_frame(input int cfg, input logic [8:0] data, input int nbits,
                              input bit par_en, input bit par_bit, input int nstop,
                              input bit stop2_low);
        set_line(cfg, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            set_line(cfg, data[i]);
            repeat (CPB) @(negedge clk);
        end
        if (par_en) begin
            set_line(cfg, par_bit);
            repeat (CPB) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            if (stop2_low && i == 1) begin
                // Low across the mid-bit sample, back high well before the
                // receiver's next half-bit start check.
                set_line(cfg, 1'b0);
                repeat (CPB * 2 / 3) @(negedge clk);
                set_line(cfg, 1'b1);
                repeat (CPB - CPB * 2 / 3) @(negedge clk);
            end else begin
                set_line(cfg, 1'b1);
                repeat (CPB) @(negedge clk);
            end
        end
        set_line(cfg, 1'b1);
        repeat (CPB) @(negedge clk);
    endtask

    // Started on the same negedge as the frame's falling edge. Waits (bounded)
    // for rx_valid, checks arrival time and the head entry fields.
    task automatic expect_entry(input string name, input int cfg, input int nframe,
                                input logic [8:0] exp_data, input bit exp_perr,
                                input bit exp_ferr, input bit exp_brk);
        int n;
        int exp_lat;
        bit seen;
        logic [8:0] d;
        logic [2:0] fl;
        n = 0;
        seen = 1'b0;
        d = '0;
        fl = '0;
        exp_lat = (2 * nframe + 1) * CPB / 2 + 4;
        while (!seen && n < exp_lat + 4 * CPB) begin
            @(negedge clk);
            n++;
            if (get_valid(cfg)) begin
                seen = 1'b1;
                d = get_data(cfg);
                fl = get_flags(cfg);
            end
        end
        chk({name, "_arrive"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            checks++;
            if (n < exp_lat - 2 || n > exp_lat + 2) begin
                errors++;
                $display("FAIL %s_latency actual=%0d required=%0d+-2", name, n, exp_lat);
            end
            chk({name, "_data"}, {23'd0, d}, {23'd0, exp_data});
            chk({name, "_perr"}, {31'd0, fl[0]}, {31'd0, exp_perr});
            chk({name, "_ferr"}, {31'd0, fl[1]}, {31'd0, exp_ferr});
            chk({name, "_brk"}, {31'd0, fl[2]}, {31'd0, exp_brk});
        end
    endtask

    initial begin
        int base;
        int n;
        bit ok;
        string nm;

        //          cfg data    nb pe pb ns s2   exp    pe fe bk
        vecs[0] = '{0, 9'h055, 8, 0, 0, 1, 0, 9'h055, 0, 0, 0};
        vecs[1] = '{0, 9'h0A3, 8, 0, 0, 1, 0, 9'h0A3, 0, 0, 0};
        vecs[2] = '{1, 9'h041, 7, 1, 0, 1, 0, 9'h041, 0, 0, 0};
        vecs[3] = '{1, 9'h041, 7, 1, 1, 1, 0, 9'h041, 1, 0, 0};
        vecs[4] = '{2, 9'h03C, 8, 0, 0, 2, 1, 9'h03C, 0, 1, 0};
        vecs[5] = '{2, 9'h03C, 8, 0, 0, 2, 0, 9'h03C, 0, 0, 0};
        vecs[6] = '{0, 9'h000, 8, 0, 0, 1, 0, 9'h000, 0, 0, 0};
        vecs[7] = '{0, 9'h0FF, 8, 0, 0, 1, 0, 9'h0FF, 0, 0, 0};

        rx_a = 1'b1; rx_p = 1'b1; rx_s = 1'b1; rx_f = 1'b1;
        rdy_a = 1'b1; rdy_p = 1'b1; rdy_s = 1'b1; rdy_f = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        for (int c = 0; c < 4; c++) begin
            nm = $sformatf("rst%0d", c);
            chk({nm, "_valid"}, {31'd0, get_valid(c)}, 32'd0);
            chk({nm, "_count"}, get_count(c), 32'd0);
            chk({nm, "_busy"}, {31'd0, get_busy(c)}, 32'd0);
            chk({nm, "_data"}, {23'd0, get_data(c)}, 32'd0);
        end
        chk("rst_overrun", {28'd0, ovr_a, ovr_p, ovr_s, ovr_f}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            nm = $sformatf("vec%0d", i);
            fork
                send_frame(vecs[i].cfg, vecs[i].data, vecs[i].nbits, vecs[i].par_en,
                           vecs[i].par_bit, vecs[i].nstop, vecs[i].stop2_low);
                expect_entry(nm, vecs[i].cfg,
                             vecs[i].nbits + int'(vecs[i].par_en) + vecs[i].nstop,
                             vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr,
                             vecs[i].exp_brk);
            join
            repeat (CPB) @(negedge clk);
        end

        // Glitch shorter than half a bit
        base = pops_a;
        rx_a = 1'b0;
        repeat (30) @(negedge clk);
        chk("glitch_busy_high", {31'd0, bsy_a}, 32'd1);
        repeat (10) @(negedge clk);
        rx_a = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 90) begin
            @(negedge clk);
            n++;
            if (!bsy_a) ok = 1'b1;
        end
        chk("glitch_busy_clear", {31'd0, ok}, 32'd1);
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_no_push", pops_a, base);
        fork
            send_frame(0, 9'h07E, 8, 0, 0, 1, 0);
            expect_entry("post_glitch", 0, 9, 9'h07E, 0, 0, 0);
        join

        // Break: line low for 20 bit times
        base = pops_a;
        fork
            begin
                rx_a = 1'b0;
                repeat (20 * CPB) @(negedge clk);
                rx_a = 1'b1;
            end
            expect_entry("break", 0, 9, 9'h000, 0, 1, 1);
        join
        repeat (2 * CPB) @(negedge clk);
        chk("break_one_entry", pops_a, base + 1);
        chk("break_idle", {31'd0, bsy_a}, 32'd0);

        // Reset in the middle of a frame with the line held low
        rx_a = 1'b0;
        repeat (300) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_valid", {31'd0, vld_a}, 32'd0);
        chk("midrst_busy", {31'd0, bsy_a}, 32'd0);
        chk("midrst_count", {27'd0, cnt_a}, 32'd0);
        reset = 1'b0;
        base = pops_a;
        repeat (12 * CPB) @(negedge clk);
        chk("midrst_low_no_push", pops_a, base);
        rx_a = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("midrst_high_no_push", pops_a, base);
        chk("midrst_idle", {31'd0, bsy_a}, 32'd0);
        fork
            send_frame(0, 9'h05A, 8, 0, 0, 1, 0);
            expect_entry("post_reset", 0, 9, 9'h05A, 0, 0, 0);
        join

        // Fill a 4-deep FIFO with rx_ready low, then overflow it
        for (int i = 1; i <= 4; i++) begin
            send_frame(3, 9'(i), 8, 0, 0, 1, 0);
        end
        chk("full_count4", get_count(3), 32'd4);
        chk("full_no_overrun_yet", ovr_cnt_f, 32'd0);
        send_frame(3, 9'h005, 8, 0, 0, 1, 0);
        repeat (CPB) @(negedge clk);
        chk("full_count_held", get_count(3), 32'd4);
        chk("full_overrun_once", ovr_cnt_f, 32'd1);
        rdy_f = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            nm = $sformatf("drain%0d", i);
            chk({nm, "_valid"}, {31'd0, vld_f}, 32'd1);
            chk({nm, "_data"}, {23'd0, get_data(3)}, i);
            @(negedge clk);
        end
        chk("drain_empty_valid", {31'd0, vld_f}, 32'd0);
        chk("drain_flags", {29'd0, get_flags(3)}, 32'd0);

        // Final state
        for (int c = 0; c < 4; c++) begin
            nm = $sformatf("end%0d", c);
            chk({nm, "_count"}, get_count(c), 32'd0);
            chk({nm, "_busy"}, {31'd0, get_busy(c)}, 32'd0);
        end
        chk("no_overrun_others", ovr_cnt_a + ovr_cnt_p + ovr_cnt_s, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #(90000 * 50);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
